// File: rtl/proc_pkg.sv
// proc_pkg: shared state encoding and default sizing for the fetch sequencer
package proc_pkg;
    localparam int PROC_ADDR_W      = 4;
    localparam int PROC_ACK_TIMEOUT = 8;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_FETCH, ST_LOAD, ST_EXEC, ST_UPDATE, ST_HALTED, ST_FAULT
    } state_e;
    function automatic logic is_busy(input state_e s);
        return !(s == ST_IDLE || s == ST_HALTED);
    endfunction
endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: control/status bundle between the fetch sequencer and its PC, memory and execute neighbours
interface fetch_seq_if
    import proc_pkg::*;
#(
    parameter int ADDR_W = PROC_ADDR_W
);
    logic              start, halt, mem_ack, exec_done, branch_taken;
    logic [ADDR_W-1:0] branch_target, pc_value, pc_datain;
    logic              pc_inc, pc_write_en, pc_clear, mem_req, ir_load, busy, fault, wrapped;
    modport master (
        input  start, halt, mem_ack, exec_done, branch_taken, branch_target, pc_value,
        output pc_inc, pc_write_en, pc_clear, pc_datain, mem_req, ir_load, busy, fault, wrapped
    );
    modport slave (
        output start, halt, mem_ack, exec_done, branch_taken, branch_target, pc_value,
        input  pc_inc, pc_write_en, pc_clear, pc_datain, mem_req, ir_load, busy, fault, wrapped
    );
endinterface

// File: rtl/ack_timer.sv
// ack_timer: saturating wait counter; expired flags the cycle on which LIMIT enabled cycles are reached
module ack_timer #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : (en && cnt_q != CW'(LIMIT)) ? cnt_q + 1'b1 : cnt_q;
    assign expired = en && cnt_q == CW'(LIMIT - 1);
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: fetch/execute sequencer driving PC, instruction memory and IR controls
// All outputs are flops loaded from the next state, so they line up with the state they belong to.
module fetch_seq
    import proc_pkg::*;
#(
    parameter int ADDR_W      = PROC_ADDR_W,
    parameter int ACK_TIMEOUT = PROC_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    fetch_seq_if.master bus
);
    state_e            state_q, state_d;
    logic              taken_q, taken_d, halt_seen_q, halt_seen_d, expired;
    logic [ADDR_W-1:0] target_q, target_d;
    logic pc_inc_q, pc_inc_d, pc_we_q, pc_we_d, pc_clear_q, pc_clear_d;
    logic mem_req_q, mem_req_d, ir_load_q, ir_load_d, busy_q, busy_d;
    logic fault_q, fault_d, wrapped_q, wrapped_d;

    ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != ST_FETCH),
        .en      (state_q == ST_FETCH && !bus.mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = bus.start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR:  state_d = ST_FETCH;
            ST_FETCH:  state_d = bus.mem_ack ? ST_LOAD : expired ? ST_FAULT : ST_FETCH;
            ST_LOAD:   state_d = ST_EXEC;
            ST_EXEC:   state_d = bus.exec_done ? ST_UPDATE : ST_EXEC;
            ST_UPDATE: state_d = (halt_seen_q || bus.halt) ? ST_HALTED : ST_FETCH;
            default:   state_d = state_q;
        endcase
        taken_d     = (state_q == ST_EXEC && bus.exec_done) ? bus.branch_taken : taken_q;
        target_d    = (state_q == ST_EXEC && bus.exec_done) ? bus.branch_target : target_q;
        // halt is remembered per instruction and forgotten once its UPDATE is done
        halt_seen_d = (state_q == ST_UPDATE) ? 1'b0
                    : halt_seen_q || (bus.halt && state_q inside {ST_FETCH, ST_LOAD, ST_EXEC});
        pc_inc_d    = state_d == ST_UPDATE && !taken_d;
        pc_we_d     = state_d == ST_UPDATE && taken_d;
        pc_clear_d  = state_d == ST_CLEAR;
        mem_req_d   = state_d == ST_FETCH;
        ir_load_d   = state_d == ST_LOAD;
        busy_d      = is_busy(state_d);
        fault_d     = fault_q || state_d == ST_FAULT;
        wrapped_d   = wrapped_q || (pc_inc_q && &bus.pc_value);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            taken_q     <= 1'b0;
            target_q    <= '0;
            halt_seen_q <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_we_q     <= 1'b0;
            pc_clear_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            ir_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            halt_seen_q <= halt_seen_d;
            pc_inc_q    <= pc_inc_d;
            pc_we_q     <= pc_we_d;
            pc_clear_q  <= pc_clear_d;
            mem_req_q   <= mem_req_d;
            ir_load_q   <= ir_load_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            wrapped_q   <= wrapped_d;
        end
    end

    assign bus.pc_inc      = pc_inc_q;
    assign bus.pc_write_en = pc_we_q;
    assign bus.pc_clear    = pc_clear_q;
    assign bus.pc_datain   = target_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.ir_load     = ir_load_q;
    assign bus.busy        = busy_q;
    assign bus.fault       = fault_q;
    assign bus.wrapped     = wrapped_q;
endmodule
